ps2_key_ctrl: RTL
=================

# ps2_key_ctrl

Scancode sequencer between the PS/2 frame receiver and the display/consumer logic on the Nvboard. Accepts one byte per strobe from the receiver and decodes PS/2 set-2 prefixes (E0 extended, F0 break). Emits complete make/break key events into a small FIFO with a valid/ready consumer handshake. Also tracks the currently held key, its ASCII translation and a press counter for the seven-segment display path.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- CNT_W, 8, press counter width.
- clk  input  1  system clock.
- resetn  input  1  reset, synchronous, active-low.
- rx_data  input  8  received scancode byte, already parity/start/stop checked.
- rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure to receiver.
- evt_valid  output  1  FIFO non-empty.
- evt_ready  input  1  consumer pops head when evt_valid && evt_ready.
- evt_data  output  18  head event {ext, brk, code[7:0], ascii[7:0]}.
- key_down  output  1  a key is currently held.
- cur_code  output  8  code of most recent make (held or last released).
- cur_ascii  output  8  ASCII of cur_code; 0 if extended/unmapped.
- press_cnt  output  CNT_W  count of distinct presses, wraps.
- overflow  output  1  sticky: an event was dropped on full FIFO.

## Operation
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Input is consumed only on rx_valid.
- IDLE: E0 -> GOT_E0; F0 -> GOT_F0; code byte -> make event (ext=0), stay IDLE.
- GOT_E0: F0 -> GOT_E0F0; E0 -> GOT_E0; code -> make event ext=1, -> IDLE.
- GOT_F0: F0 -> stay; E0 -> GOT_E0 (prefix dropped); code -> break event ext=0, -> IDLE.
- GOT_E0F0: F0 -> stay; E0 -> GOT_E0; code -> break event ext=1, -> IDLE.
- Control bytes 00, AA, EE, FA, FE, FF in any state: no event, FSM -> IDLE.
- Make, and (key_down && code==cur_code && ext matches): treated as a typematic repeat. Nothing is pushed and press_cnt is unchanged.
- Other make:
  - push event;
  - key_down=1;
  - cur_code=code, cur_ascii=lookup (0 when ext);
  - press_cnt+1, wrapping mod 2^CNT_W.
- Break:
  - always push event;
  - if the code/ext matches the held key, key_down=0;
  - cur_code and cur_ascii retain their value.
- Break of any other key leaves key_down unchanged. Only the last-pressed key is tracked.
- The event ascii field equals lookup(code) for ext=0, and 0 for ext=1.
- Push when FIFO full and no pop in the same cycle: event dropped, overflow=1 until reset.

## Timing
- Reset values:
  - evt_valid=0, evt_data=0 (head reads 0 when empty);
  - key_down=0, cur_code=0, cur_ascii=0, press_cnt=0, overflow=0;
  - FSM=IDLE, FIFO empty.
- Latency: rx_valid at edge N (completing byte) -> evt_valid and key_down/cur_* updated after edge N. They are visible in cycle N+1.
- FIFO is first-word-fall-through. evt_data is stable while evt_valid && !evt_ready.
- Simultaneous push and pop when full: both occur, no drop, occupancy unchanged.
- Simultaneous push and pop when empty: the event is written and becomes visible next cycle. The pop is ignored because evt_valid=0.
- Back-to-back rx_valid on consecutive cycles is fully supported.
- Reset mid-sequence (e.g. after F0): the prefix is discarded and the next code decodes as a make.

## Configuration
- PS2_ASCII_EN defined: ps2_ascii_rom is instantiated. ascii and cur_ascii carry set-2-to-ASCII translation for letters, digits, space, enter; other codes give 0.
- PS2_ASCII_EN undefined: no ROM is instantiated, and ascii and cur_ascii are tied to 0. All other behaviour is identical.

## Structure
- Package ps2_pkg holds:
  - FSM state enum;
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, and control-byte constants;
  - event struct/field offsets (EVT_W=18).
- Sub-module ps2_ascii_rom: combinational 8-bit code -> 8-bit ASCII lookup, unmapped -> 0. Compiled only under PS2_ASCII_EN.
- The FIFO is inline: pointer/count registers plus an array.

## Test plan
- 1C, F0 1C -> two events {0,0,1C,61} then {0,1,1C,61}. press_cnt=1, key_down 1 then 0, cur_ascii=61.
- E0 75, E0 F0 75 -> events {1,0,75,00} and {1,1,75,00}. cur_ascii=0.
- 1C,1C,1C (typematic), F0 1C -> exactly 2 events, press_cnt=1.
- 9 makes of distinct codes with evt_ready=0, DEPTH=8 -> 8 events held, overflow=1, 9th dropped. Full with simultaneous pop+push -> no drop.
- F0, reset asserted one cycle, then 1C -> make event {0,0,1C,..}, outputs zeroed during reset.
- AA between bytes (E0, AA, 75) -> 75 decoded as make ext=0. 256 distinct press/release pairs -> press_cnt wraps to 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scancode sequencer.
// The optional ASCII translation is selected with the PS2_ASCII_EN macro.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam int EVT_W = 18;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } ps2_evt_t;

    // Keyboard status/reply bytes: they never form part of a key sequence.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == PS2_ERR0)   || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
               (b == PS2_ACK)    || (b == PS2_RESEND) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Set-2 scancode to ASCII lookup (lowercase letters, digits, space, enter).
// Only compiled when PS2_ASCII_EN is defined; unmapped codes give 0.
`ifdef PS2_ASCII_EN
module ps2_ascii_rom (
    input  logic [7:0] code_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        case (code_i)
            8'h1C: ascii_o = 8'h61; 8'h32: ascii_o = 8'h62; 8'h21: ascii_o = 8'h63;
            8'h23: ascii_o = 8'h64; 8'h24: ascii_o = 8'h65; 8'h2B: ascii_o = 8'h66;
            8'h34: ascii_o = 8'h67; 8'h33: ascii_o = 8'h68; 8'h43: ascii_o = 8'h69;
            8'h3B: ascii_o = 8'h6A; 8'h42: ascii_o = 8'h6B; 8'h4B: ascii_o = 8'h6C;
            8'h3A: ascii_o = 8'h6D; 8'h31: ascii_o = 8'h6E; 8'h44: ascii_o = 8'h6F;
            8'h4D: ascii_o = 8'h70; 8'h15: ascii_o = 8'h71; 8'h2D: ascii_o = 8'h72;
            8'h1B: ascii_o = 8'h73; 8'h2C: ascii_o = 8'h74; 8'h3C: ascii_o = 8'h75;
            8'h2A: ascii_o = 8'h76; 8'h1D: ascii_o = 8'h77; 8'h22: ascii_o = 8'h78;
            8'h35: ascii_o = 8'h79; 8'h1A: ascii_o = 8'h7A;
            8'h45: ascii_o = 8'h30; 8'h16: ascii_o = 8'h31; 8'h1E: ascii_o = 8'h32;
            8'h26: ascii_o = 8'h33; 8'h25: ascii_o = 8'h34; 8'h2E: ascii_o = 8'h35;
            8'h36: ascii_o = 8'h36; 8'h3D: ascii_o = 8'h37; 8'h3E: ascii_o = 8'h38;
            8'h46: ascii_o = 8'h39;
            8'h29: ascii_o = 8'h20;
            8'h5A: ascii_o = 8'h0D;
            default: ascii_o = 8'h00;
        endcase
    end

endmodule
`endif

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 scancode sequencer: prefix decode, held-key tracking, event FIFO.
// Define PS2_ASCII_EN to enable ASCII translation; otherwise ascii fields are 0.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic             key_down,
    output logic [7:0]       cur_code,
    output logic [7:0]       cur_ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    ps2_state_e       state_q;
    logic             key_down_q;
    logic             cur_ext_q;
    logic [7:0]       cur_code_q;
    logic [7:0]       cur_ascii_q;
    logic [CNT_W-1:0] press_cnt_q;
    logic             overflow_q;

    ps2_evt_t         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic [7:0] code_ascii;
    logic       is_ctrl, is_code, evt_ext, evt_brk, held_match;
    logic       new_press, is_break, push, pop, full, wr_en, drop_d;
    ps2_evt_t   evt_d;

`ifdef PS2_ASCII_EN
    ps2_ascii_rom u_ascii_rom (
        .code_i  (rx_data),
        .ascii_o (code_ascii)
    );
`else
    assign code_ascii = 8'h00;
`endif

    always_comb begin
        is_ctrl    = is_ctrl_byte(rx_data);
        is_code    = rx_valid && !is_ctrl && (rx_data != PS2_EXT) && (rx_data != PS2_BRK);
        evt_ext    = (state_q == ST_GOT_E0) || (state_q == ST_GOT_E0F0);
        evt_brk    = (state_q == ST_GOT_F0) || (state_q == ST_GOT_E0F0);
        evt_d      = '{ext: evt_ext, brk: evt_brk, code: rx_data,
                       ascii: (evt_ext ? 8'h00 : code_ascii)};
        held_match = key_down_q && (cur_code_q == rx_data) && (cur_ext_q == evt_ext);
        // A make of the key already held is typematic auto-repeat, not a press.
        new_press  = is_code && !evt_brk && !held_match;
        is_break   = is_code && evt_brk;
        push       = new_press || is_break;
        pop        = (count_q != '0) && evt_ready;
        full       = (count_q == DEPTH_C);
        wr_en      = push && (!full || pop);
        drop_d     = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            key_down_q  <= 1'b0;
            cur_ext_q   <= 1'b0;
            cur_code_q  <= 8'h00;
            cur_ascii_q <= 8'h00;
            press_cnt_q <= '0;
        end else begin
            if (rx_valid) begin
                if (is_ctrl) begin
                    state_q <= ST_IDLE;
                end else if (rx_data == PS2_EXT) begin
                    state_q <= ST_GOT_E0;
                end else if (rx_data == PS2_BRK) begin
                    case (state_q)
                        ST_IDLE:     state_q <= ST_GOT_F0;
                        ST_GOT_E0:   state_q <= ST_GOT_E0F0;
                        ST_GOT_F0:   state_q <= ST_GOT_F0;
                        ST_GOT_E0F0: state_q <= ST_GOT_E0F0;
                        default:     state_q <= ST_IDLE;
                    endcase
                end else begin
                    state_q <= ST_IDLE;
                end
            end
            if (new_press) begin
                key_down_q  <= 1'b1;
                cur_ext_q   <= evt_ext;
                cur_code_q  <= rx_data;
                cur_ascii_q <= evt_d.ascii;
                press_cnt_q <= press_cnt_q + CNT_W'(1);
            end else if (is_break && held_match) begin
                key_down_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (wr_en && !pop)      count_q <= count_q + (PTR_W+1)'(1);
            else if (!wr_en && pop) count_q <= count_q - (PTR_W+1)'(1);
            if (drop_d) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= evt_d;
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign key_down  = key_down_q;
    assign cur_code  = cur_code_q;
    assign cur_ascii = cur_ascii_q;
    assign press_cnt = press_cnt_q;
    assign overflow  = overflow_q;

endmodule
